// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if -- operand/result handshake bundle for fp_mul_pipe.
//
// Signals (W = 1 + EXP_W + MAN_W):
//   in_valid  : operands a, b present
//   in_ready  : multiplier accepts operands this cycle
//   a, b      : operands {sign, exponent, mantissa}
//   out_valid : product and flags valid
//   out_ready : downstream accepts the product
//   out       : product
//   overflow  : result exceeded the maximum finite value
//   underflow : nonzero result flushed to zero
//   invalid   : NaN operand, or infinity times zero
//
// master: the side that supplies operands and consumes results.
// slave : the multiplier.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         overflow;
    logic         underflow;
    logic         invalid;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, overflow, underflow, invalid
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, overflow, underflow, invalid
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- three-stage pipelined floating-point multiplier.
//
// Stage p0: unpack operands and classify the operation (normal/zero/inf/NaN).
// Stage p1: full-width mantissa product and biased exponent sum.
// Stage p2: normalize, round to nearest even, saturate and pack (output register).
//
// Subnormal inputs are treated as zero and no subnormal result is produced.
// A single advance enable moves every stage at once, so a blocked output
// freezes the whole pipeline and in_ready drops in the same cycle.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; clears all valid bits and the outputs
//   bus   : fp_mul_pipe_if.slave (operand/result handshake, product, flags)
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_pipe_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int MW   = MAN_W + 1;          // mantissa with hidden bit
    localparam int PW   = 2 * MW;             // full product width
    localparam int XW   = EXP_W + 2;          // signed exponent arithmetic width

    localparam logic signed [XW-1:0] BIAS_X    = XW'(BIAS);
    localparam logic signed [XW-1:0] ONE_X     = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X    = '0;
    localparam logic signed [XW-1:0] EXP_MAX_X = XW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        K_NORM,
        K_ZERO,
        K_INF,
        K_NAN
    } kind_t;

    // Normalize the raw product, then round to nearest even on guard/round/sticky.
    // Returns {exponent, stored mantissa}; the exponent is not yet range-checked.
    function automatic logic [XW+MAN_W-1:0] rne_round(
        input logic        [PW-1:0] prod,
        input logic signed [XW-1:0] exp_in
    );
        logic        [PW-1:0] norm;
        logic signed [XW-1:0] exp_v;
        logic        [MW-1:0] mant;
        logic        [MW:0]   mant_r;
        logic                 guard;
        logic                 rnd;
        logic                 sticky;
        logic                 up;
        // Product of two [1,2) mantissas lies in [1,4); align the leading one to the top.
        if (prod[PW-1]) begin
            norm  = prod;
            exp_v = exp_in + ONE_X;
        end else begin
            norm  = prod << 1;
            exp_v = exp_in;
        end
        mant   = norm[PW-1 -: MW];
        guard  = norm[MAN_W];
        rnd    = norm[MAN_W-1];
        sticky = |norm[MAN_W-2:0];
        up     = guard & (rnd | sticky | mant[0]);
        mant_r = {1'b0, mant} + {{MW{1'b0}}, up};
        // Rounding all-ones up carries into a new leading bit: 10.00..0 -> 1.000..0, exp+1.
        if (mant_r[MW]) begin
            mant_r = mant_r >> 1;
            exp_v  = exp_v + ONE_X;
        end
        return {exp_v, mant_r[MAN_W-1:0]};
    endfunction

    // Apply special-case results and exponent saturation.
    // Returns {product, overflow, underflow, invalid}.
    function automatic logic [W+2:0] pack_result(
        input logic                 sign,
        input kind_t                kind,
        input logic signed [XW-1:0] exp_v,
        input logic        [MAN_W-1:0] man_v
    );
        logic [W+2:0] res;
        case (kind)
            K_NAN:   res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}, 3'b001};
            K_INF:   res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}, 3'b000};
            K_ZERO:  res = {sign, {(W-1){1'b0}}, 3'b000};
            default: begin
                if (exp_v >= EXP_MAX_X) begin
                    res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}, 3'b100};
                end else if (exp_v <= ZERO_X) begin
                    res = {sign, {(W-1){1'b0}}, 3'b010};
                end else begin
                    res = {sign, exp_v[EXP_W-1:0], man_v, 3'b000};
                end
            end
        endcase
        return res;
    endfunction

    logic adv;

    logic                    vld_p0;
    kind_t                   kind_p0;
    logic                    sign_p0;
    logic [EXP_W-1:0]        ea_p0;
    logic [EXP_W-1:0]        eb_p0;
    logic [MW-1:0]           ma_p0;
    logic [MW-1:0]           mb_p0;

    logic                    vld_p1;
    kind_t                   kind_p1;
    logic                    sign_p1;
    logic [PW-1:0]           prod_p1;
    logic signed [XW-1:0]    exp_p1;

    logic                    vld_p2;
    logic [W-1:0]            out_p2;
    logic                    ovf_p2;
    logic                    unf_p2;
    logic                    inv_p2;

    // Every stage advances together; the output register is the only place a stall starts.
    assign adv          = ~vld_p2 | bus.out_ready;
    assign bus.in_ready = adv;

    // ---- Stage p0: unpack and classify ----
    logic             a_sign;
    logic             b_sign;
    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;
    logic             a_zero;
    logic             b_zero;
    logic             a_inf;
    logic             b_inf;
    logic             a_nan;
    logic             b_nan;
    kind_t            kind_in;

    assign {a_sign, a_exp, a_man} = bus.a;
    assign {b_sign, b_exp, b_man} = bus.b;

    // exp == 0 covers both true zero and subnormals, which flush to zero.
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) & ~(|a_man);
    assign b_inf  = (&b_exp) & ~(|b_man);
    assign a_nan  = (&a_exp) & (|a_man);
    assign b_nan  = (&b_exp) & (|b_man);

    always_comb begin
        kind_in = K_NORM;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            kind_in = K_NAN;
        end else if (a_inf | b_inf) begin
            kind_in = K_INF;
        end else if (a_zero | b_zero) begin
            kind_in = K_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            kind_p0 <= kind_in;
            sign_p0 <= a_sign ^ b_sign;
            ea_p0   <= a_exp;
            eb_p0   <= b_exp;
            ma_p0   <= {1'b1, a_man};
            mb_p0   <= {1'b1, b_man};
        end
    end

    // ---- Stage p1: mantissa product and exponent sum ----
    logic [PW-1:0]        prod_nx;
    logic signed [XW-1:0] exp_nx;

    assign prod_nx = PW'(ma_p0) * PW'(mb_p0);
    // Two extra bits keep ea+eb-BIAS from wrapping at either end of the range.
    assign exp_nx  = $signed({2'b00, ea_p0}) + $signed({2'b00, eb_p0}) - BIAS_X;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            kind_p1 <= kind_p0;
            sign_p1 <= sign_p0;
            prod_p1 <= prod_nx;
            exp_p1  <= exp_nx;
        end
    end

    // ---- Stage p2: normalize, round, pack (output register) ----
    logic signed [XW-1:0] exp_rnd;
    logic [MAN_W-1:0]     man_rnd;
    logic [W+2:0]         res_nx;

    assign {exp_rnd, man_rnd} = rne_round(prod_p1, exp_p1);
    assign res_nx             = pack_result(sign_p1, kind_p1, exp_rnd, man_rnd);

    // Output data is cleared on reset so a reset leaves all outputs at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            out_p2 <= '0;
            ovf_p2 <= 1'b0;
            unf_p2 <= 1'b0;
            inv_p2 <= 1'b0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                {out_p2, ovf_p2, unf_p2, inv_p2} <= res_nx;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out       = out_p2;
    assign bus.overflow  = ovf_p2;
    assign bus.underflow = unf_p2;
    assign bus.invalid   = inv_p2;
endmodule
